uart_rx_ctrl: RTL and testbench

Receive-side control and datapath for the UART RX: consumes the edge/bit counts produced by the RX edge/bit counter, enables that counter for the duration of a frame, samples RX_IN at mid-bit, deserializes LSB-first data, checks start, parity and stop bits, and emits a one-cycle data_valid with the received byte. It sits between the serial input pin and the system-side consumer (register file / FIFO write port).

---
 rtl/uart_rx_pkg.sv | 25 ++
 rtl/uart_rx_sampler.sv | 54 +++++
 rtl/uart_rx_ctrl.sv | 110 +++++++++++
 tb/tb_uart_rx_ctrl.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive control path.
// Optional feature macro: UART_RX_OVERSAMPLE3_EN (majority-of-3 sampling).
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  localparam int START_BIT     = 1;
  localparam int LAST_DATA_BIT = 9;
  localparam int PAR_BIT       = 10;

  localparam int PRESCALE_8  = 8;
  localparam int PRESCALE_16 = 16;
  localparam int PRESCALE_32 = 32;

  function automatic logic maj3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Mid-bit sampler: majority of three samples, or a single mid sample.
// UART_RX_OVERSAMPLE3_EN selects the three-sample variant.
module uart_rx_sampler
  import uart_rx_pkg::*;
#(
  parameter int PW = 6
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          rx_i,
  input  logic [PW-1:0] prescale_i,
  input  logic [PW-1:0] edge_cnt_i,
  output logic          bit_o
);

  logic [PW-1:0] mid;
  assign mid = prescale_i >> 1;

`ifdef UART_RX_OVERSAMPLE3_EN
  logic [2:0]    smp_q;
  logic [PW-1:0] mid_lo;
  logic [PW-1:0] mid_hi;
  logic          hit;

  assign mid_lo = mid - PW'(1);
  assign mid_hi = mid + PW'(1);
  assign hit    = (edge_cnt_i == mid_lo) ||
                  (edge_cnt_i == mid)    ||
                  (edge_cnt_i == mid_hi);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      smp_q <= '0;
    end else if (hit) begin
      smp_q <= {smp_q[1:0], rx_i};
    end
  end

  assign bit_o = maj3(smp_q);
`else
  logic smp_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      smp_q <= 1'b0;
    end else if (edge_cnt_i == mid) begin
      smp_q <= rx_i;
    end
  end

  assign bit_o = smp_q;
`endif

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART RX control FSM: frames, deserializes and checks one byte.
// Sampling mode set by UART_RX_OVERSAMPLE3_EN (see uart_rx_sampler).
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6,
  parameter int BIT_CNT_WIDTH  = 4
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      RX_IN,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  input  logic [PRESCALE_WIDTH-1:0] edge_cnt,
  input  logic [BIT_CNT_WIDTH-1:0]  bit_cnt,
  output logic                      cnt_enable,
  output logic [DATA_WIDTH-1:0]     P_DATA,
  output logic                      data_valid,
  output logic                      par_err,
  output logic                      stp_err,
  output logic                      strt_glitch
);

  state_e                state_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic                  glitch_q;
  logic                  par_bad_q;
  logic                  dec;
  logic                  bnd;
  logic                  last_data;

  uart_rx_sampler #(
    .PW(PRESCALE_WIDTH)
  ) u_sampler (
    .clk_i     (CLK),
    .rst_i     (RST),
    .rx_i      (RX_IN),
    .prescale_i(prescale),
    .edge_cnt_i(edge_cnt),
    .bit_o     (dec)
  );

  assign bnd        = (edge_cnt == prescale);
  assign last_data  = (bit_cnt == BIT_CNT_WIDTH'(LAST_DATA_BIT));
  assign cnt_enable = (state_q != IDLE);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      glitch_q    <= 1'b0;
      par_bad_q   <= 1'b0;
      P_DATA      <= '0;
      data_valid  <= 1'b0;
      par_err     <= 1'b0;
      stp_err     <= 1'b0;
      strt_glitch <= 1'b0;
    end else begin
      data_valid  <= 1'b0;
      par_err     <= 1'b0;
      stp_err     <= 1'b0;
      strt_glitch <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (!RX_IN) state_q <= START;
        end
        START: begin
          if (bnd) begin
            glitch_q <= dec;
            state_q  <= DATA;
          end
        end
        DATA: begin
          if (bnd) begin
            shift_q <= {dec, shift_q[DATA_WIDTH-1:1]};
            if (last_data) state_q <= PAR_EN ? PARITY : STOP;
          end
        end
        PARITY: begin
          if (bnd) begin
            par_bad_q <= dec != (^shift_q ^ PAR_TYP);
            state_q   <= STOP;
          end
        end
        STOP: begin
          if (bnd) begin
            state_q   <= IDLE;
            glitch_q  <= 1'b0;
            par_bad_q <= 1'b0;
            // one status per frame, highest-priority fault wins
            if (glitch_q) begin
              strt_glitch <= 1'b1;
            end else if (par_bad_q) begin
              par_err <= 1'b1;
            end else if (!dec) begin
              stp_err <= 1'b1;
            end else begin
              data_valid <= 1'b1;
              P_DATA     <= shift_q;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: directed and random frames against a frame-level model.
// Honours UART_RX_OVERSAMPLE3_EN when predicting mid-bit glitch effects.
module tb_uart_rx_ctrl;

`ifdef UART_RX_OVERSAMPLE3_EN
  localparam bit OVS = 1'b1;
`else
  localparam bit OVS = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       RST = 1'b1;
  logic       RX_IN = 1'b1;
  logic [5:0] prescale = 6'd8;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic [5:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic       cnt_enable;
  logic [7:0] P_DATA;
  logic       data_valid;
  logic       par_err;
  logic       stp_err;
  logic       strt_glitch;

  int total = 0;
  int bad = 0;
  logic [7:0] last_good = 8'h00;

  always #5 clk = ~clk;

  uart_rx_ctrl dut (
    .CLK        (clk),
    .RST        (RST),
    .RX_IN      (RX_IN),
    .prescale   (prescale),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .edge_cnt   (edge_cnt),
    .bit_cnt    (bit_cnt),
    .cnt_enable (cnt_enable),
    .P_DATA     (P_DATA),
    .data_valid (data_valid),
    .par_err    (par_err),
    .stp_err    (stp_err),
    .strt_glitch(strt_glitch)
  );

  // environment: the external edge/bit counter
  always @(posedge clk) begin
    if (RST || !cnt_enable) begin
      edge_cnt <= 6'd1;
      bit_cnt  <= 4'd1;
    end else if (edge_cnt == prescale) begin
      edge_cnt <= 6'd1;
      bit_cnt  <= bit_cnt + 4'd1;
    end else begin
      edge_cnt <= edge_cnt + 6'd1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // p: prescale, d: byte, flip: corrupt parity, stp: stop level,
  // sg: start bit high at mid, gb: data bit with mid glitch (-1 none)
  task automatic frame(input int p, input logic pe, input logic pt,
                       input logic [7:0] d, input logic flip,
                       input logic stp, input logic sg, input int gb);
    int nb, n, k, e, mid, stray;
    logic v, pb;
    logic [7:0] sd;
    logic [3:0] exp_st;
    prescale = p[5:0];
    PAR_EN   = pe;
    PAR_TYP  = pt;
    nb    = pe ? 11 : 10;
    n     = nb * p;
    mid   = p / 2;
    pb    = (^d) ^ pt ^ flip;
    stray = 0;
    for (int c = 0; c <= n; c++) begin
      @(negedge clk);
      if (data_valid | par_err | stp_err | strt_glitch) stray++;
      if (c == 1) check("cnt_en_on", {31'd0, cnt_enable}, 32'd1);
      if (c == 0) begin
        v = 1'b0;
      end else begin
        k = (c - 1) / p;
        e = (c - 1) % p + 1;
        if (k == 0) v = sg && e >= mid - 1 && e <= mid + 1;
        else if (k <= 8) v = d[k-1] ^ (gb == k - 1 && e == mid);
        else if (k == 9 && pe) v = pb;
        else v = stp;
      end
      RX_IN = v;
    end
    @(negedge clk);
    RX_IN = 1'b1;
    sd = d;
    if (gb >= 0 && !OVS) sd[gb] = ~sd[gb];
    if (sg) exp_st = 4'b0001;
    else if (pe && pb != ((^sd) ^ pt)) exp_st = 4'b0100;
    else if (!stp) exp_st = 4'b0010;
    else begin
      exp_st    = 4'b1000;
      last_good = sd;
    end
    check("status", {28'd0, data_valid, par_err, stp_err, strt_glitch},
          {28'd0, exp_st});
    check("p_data", {24'd0, P_DATA}, {24'd0, last_good});
    check("stray", stray, 0);
    check("cnt_en_off", {31'd0, cnt_enable}, 32'd0);
  endtask

  initial begin
    int p, stray;
    logic [1:0] sel;
    repeat (3) @(negedge clk);
    RST = 1'b0;
    check("rst_out", {19'd0, cnt_enable, P_DATA, data_valid, par_err,
                      stp_err, strt_glitch}, 32'd0);

    frame(8, 0, 0, 8'hA5, 0, 1, 0, -1);
    frame(16, 1, 0, 8'h3C, 0, 1, 0, -1);
    frame(16, 1, 0, 8'h3C, 1, 1, 0, -1);
    frame(32, 0, 0, 8'h96, 0, 0, 0, -1);
    frame(32, 0, 0, 8'h55, 0, 1, 0, -1);
    frame(16, 0, 0, 8'hFF, 0, 1, 0, 3);
    frame(8, 1, 1, 8'h81, 0, 1, 0, -1);
    frame(8, 1, 1, 8'h42, 0, 1, 1, -1);
    frame(16, 1, 0, 8'h0F, 1, 0, 1, -1);

    for (int i = 0; i < 20; i++) begin
      sel = 2'($urandom_range(2));
      p = 8 << sel;
      frame(p, 1'($urandom), 1'($urandom), 8'($urandom),
            $urandom_range(3) == 0, $urandom_range(7) != 0,
            $urandom_range(7) == 0,
            $urandom_range(2) == 0 ? int'($urandom_range(7)) : -1);
    end

    // reset in the middle of a frame
    prescale = 6'd16;
    @(negedge clk);
    RX_IN = 1'b0;
    repeat (40) @(negedge clk);
    RX_IN = 1'b1;
    RST = 1'b1;
    @(negedge clk);
    RST = 1'b0;
    check("rst_mid_out", {19'd0, cnt_enable, P_DATA, data_valid, par_err,
                          stp_err, strt_glitch}, 32'd0);
    last_good = 8'h00;
    stray = 0;
    repeat (200) begin
      @(negedge clk);
      if (data_valid | par_err | stp_err | strt_glitch | cnt_enable) stray++;
    end
    check("rst_mid_quiet", stray, 0);
    frame(16, 0, 0, 8'hC3, 0, 1, 0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
